// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the TX queue controller state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } uart_tx_queue_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer/transmitter signal bundle matching the uart_tx_queue ports.
// master = producer plus transmitter side, slave = the queue.
interface uart_tx_queue_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] data;
  logic                   valid;
  logic                   ready;
  logic                   tx_start;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_done;

  modport master (output data, valid, tx_done, input ready, tx_start, tx_data);
  modport slave  (input data, valid, tx_done, output ready, tx_start, tx_data);

endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO with wrapping read/write pointers and an occupancy counter.
// Storage is not reset; only pointers and count are.
module uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   CLK_I,
  input  logic                   RST_NI,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge CLK_I) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter: pops the head into a holding register,
// pulses TX_START_O for one cycle, then waits for TX_DONE_I.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   CLK_I,
  input  logic                   RST_NI,
  input  logic [UART_DATA_W-1:0] DATA_I,
  input  logic                   VALID_I,
  output logic                   READY_O,
  output logic                   TX_START_O,
  output logic [UART_DATA_W-1:0] TX_DATA_O,
  input  logic                   TX_DONE_I,
  output logic                   FULL_O,
  output logic                   EMPTY_O,
  output logic [$clog2(DEPTH):0] COUNT_O
);

  uart_tx_queue_state_t   state;
  uart_tx_queue_state_t   state_nxt;
  logic                   pop;
  logic                   tx_start;
  logic [UART_DATA_W-1:0] head;
  logic [UART_DATA_W-1:0] tx_data_q;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .CLK_I     (CLK_I),
    .RST_NI    (RST_NI),
    .push      (VALID_I && READY_O),
    .push_data (DATA_I),
    .pop       (pop),
    .pop_data  (head),
    .full      (FULL_O),
    .empty     (EMPTY_O),
    .count     (COUNT_O)
  );

  assign READY_O    = !FULL_O;
  assign TX_START_O = tx_start;
  assign TX_DATA_O  = tx_data_q;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!EMPTY_O) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx_start  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (TX_DONE_I) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state     <= ST_IDLE;
      tx_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (pop) tx_data_q <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: vector table for the single-byte and fill
// sequences, hand-written sequences for ordering, push/pop overlap, wrap and reset.
module tb_uart_tx_queue;

  logic clk;
  logic rst_n;
  logic full;
  logic empty;
  logic [3:0] count;

  int checks;
  int failures;

  uart_tx_queue_if bus ();

  uart_tx_queue #(
    .DEPTH (8)
  ) dut (
    .CLK_I      (clk),
    .RST_NI     (rst_n),
    .DATA_I     (bus.data),
    .VALID_I    (bus.valid),
    .READY_O    (bus.ready),
    .TX_START_O (bus.tx_start),
    .TX_DATA_O  (bus.tx_data),
    .TX_DONE_I  (bus.tx_done),
    .FULL_O     (full),
    .EMPTY_O    (empty),
    .COUNT_O    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       done;
    logic       start;
    logic [7:0] txd;
    logic [3:0] cnt;
    logic       full;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Pulse done in ST_WAIT; the next start must come exactly two cycles later.
  task automatic xmit(input logic [7:0] exp_byte);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("gap_no_start", {31'd0, bus.tx_start}, 32'd0);
    tick();
    chk("b2b_start", {31'd0, bus.tx_start}, 32'd1);
    chk("b2b_data", {24'd0, bus.tx_data}, {24'd0, exp_byte});
    tick();
    chk("start_one_cycle", {31'd0, bus.tx_start}, 32'd0);
  endtask

  initial begin
    int sent;
    int got;
    int wait_cnt;
    int cyc;
    logic [7:0] expb;

    checks   = 0;
    failures = 0;
    rst_n       = 1'b0;
    bus.valid   = 1'b0;
    bus.data    = 8'h00;
    bus.tx_done = 1'b0;

    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0};
    vecs[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'hA5, 4'd1, 1'b0};
    vecs[7]  = '{1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0};
    vecs[8]  = '{1'b1, 8'h03, 1'b1, 1'b0, 8'h01, 4'd2, 1'b0};
    vecs[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h01, 4'd3, 1'b0};
    vecs[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h01, 4'd4, 1'b0};
    vecs[11] = '{1'b1, 8'h06, 1'b0, 1'b0, 8'h01, 4'd5, 1'b0};
    vecs[12] = '{1'b1, 8'h07, 1'b0, 1'b0, 8'h01, 4'd6, 1'b0};
    vecs[13] = '{1'b1, 8'h08, 1'b0, 1'b0, 8'h01, 4'd7, 1'b0};
    vecs[14] = '{1'b1, 8'h09, 1'b0, 1'b0, 8'h01, 4'd8, 1'b1};
    vecs[15] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h01, 4'd8, 1'b1};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 4'd8, 1'b1};

    #1;
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_txdata", {24'd0, bus.tx_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      bus.valid   = vecs[i].valid;
      bus.data    = vecs[i].data;
      bus.tx_done = vecs[i].done;
      tick();
      chk($sformatf("row%0d_start", i), {31'd0, bus.tx_start}, {31'd0, vecs[i].start});
      chk($sformatf("row%0d_txdata", i), {24'd0, bus.tx_data}, {24'd0, vecs[i].txd});
      chk($sformatf("row%0d_count", i), {28'd0, count}, {28'd0, vecs[i].cnt});
      chk($sformatf("row%0d_full", i), {31'd0, full}, {31'd0, vecs[i].full});
      chk($sformatf("row%0d_ready", i), {31'd0, bus.ready}, {31'd0, !vecs[i].full});
      chk($sformatf("row%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].cnt == 4'd0});
    end
    bus.valid   = 1'b0;
    bus.tx_done = 1'b0;

    // Drain 0x02..0x09; the refused 0xFF must never show up.
    for (int b = 2; b <= 9; b++) xmit(8'(b));
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("drained_no_start", {31'd0, bus.tx_start}, 32'd0);
    end
    chk("drained_empty", {31'd0, empty}, 32'd1);
    chk("drained_last_data", {24'd0, bus.tx_data}, 32'h09);

    // Simultaneous push and pop at count 3.
    bus.valid = 1'b1;
    bus.data = 8'h11; tick();
    bus.data = 8'h22; tick();
    bus.data = 8'h33; tick();
    bus.data = 8'h44; tick();
    bus.valid = 1'b0;
    chk("pp_count_before", {28'd0, count}, 32'd3);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    bus.valid = 1'b1;
    bus.data  = 8'h55;
    tick();
    bus.valid = 1'b0;
    chk("pp_count_after", {28'd0, count}, 32'd3);
    chk("pp_start", {31'd0, bus.tx_start}, 32'd1);
    chk("pp_data", {24'd0, bus.tx_data}, 32'h22);
    tick();
    xmit(8'h33);
    xmit(8'h44);
    xmit(8'h55);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;

    // Twenty bytes streamed through, wrapping the pointers.
    sent = 0;
    got = 0;
    wait_cnt = -1;
    cyc = 0;
    while (got < 20 && cyc < 2000) begin
      bus.tx_done = 1'b0;
      if (wait_cnt == 0) begin
        bus.tx_done = 1'b1;
        wait_cnt = -1;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      if (bus.tx_start) begin
        expb = 8'hC0 + 8'(got);
        chk($sformatf("stream%0d_data", got), {24'd0, bus.tx_data}, {24'd0, expb});
        got++;
        wait_cnt = 3;
      end
      bus.valid = (sent < 20) && bus.ready;
      bus.data  = 8'hC0 + 8'(sent);
      if (bus.valid) sent++;
      tick();
      cyc++;
    end
    bus.valid   = 1'b0;
    bus.tx_done = 1'b0;
    chk("stream_received", got, 32'd20);
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("stream_empty", {31'd0, empty}, 32'd1);

    // Reset while waiting on the transmitter with four bytes queued.
    bus.valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      bus.data = 8'h61 + 8'(b);
      tick();
    end
    bus.valid = 1'b0;
    tick();
    tick();
    chk("prerst_count", {28'd0, count}, 32'd4);
    chk("prerst_txdata", {24'd0, bus.tx_data}, 32'h61);
    rst_n = 1'b0;
    #2;
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_start", {31'd0, bus.tx_start}, 32'd0);
    chk("midrst_count", {28'd0, count}, 32'd0);
    chk("midrst_txdata", {24'd0, bus.tx_data}, 32'd0);
    chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("postrst_no_start", {31'd0, bus.tx_start}, 32'd0);
    end
    bus.valid = 1'b1;
    bus.data  = 8'h77;
    tick();
    bus.valid = 1'b0;
    chk("postrst_no_bypass", {31'd0, bus.tx_start}, 32'd0);
    tick();
    chk("postrst_start", {31'd0, bus.tx_start}, 32'd1);
    chk("postrst_data", {24'd0, bus.tx_data}, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 8, SHALL be the byte-queue depth, a power of two, at least 2.
REQ-002 CLK_I  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST_NI  input  1  SHALL be the asynchronous active-low reset.
REQ-004 DATA_I  input  8  SHALL be the byte offered by the producer.
REQ-005 VALID_I  input  1  SHALL indicate that DATA_I is offered; a push occurs when VALID_I and READY_O are both 1.
REQ-006 READY_O  output  1  SHALL be 1 when the queue can accept a byte, equal to !FULL_O.
REQ-007 TX_START_O  output  1  SHALL be the one-cycle start pulse to the transmitter.
REQ-008 TX_DATA_O  output  8  SHALL be the byte to transmit, valid while TX_START_O=1.
REQ-009 TX_DONE_I  input  1  SHALL be the transmitter's one-cycle frame-complete pulse.
REQ-010 FULL_O  output  1  SHALL be 1 when COUNT_O equals DEPTH.
REQ-011 EMPTY_O  output  1  SHALL be 1 when COUNT_O equals 0.
REQ-012 COUNT_O  output  $clog2(DEPTH)+1  SHALL be the number of bytes stored, excluding the byte in flight.

Function
REQ-013 The block SHALL use a FIFO with read/write pointers of width $clog2(DEPTH), wrapping modulo DEPTH.
REQ-014 FSM states SHALL be ST_IDLE, ST_START, and ST_WAIT.
REQ-015 ST_IDLE with EMPTY_O=0 SHALL pop the head byte into a TX_DATA_O holding register and move to ST_START on the next edge.
REQ-016 ST_START SHALL assert TX_START_O for exactly one cycle, then move to ST_WAIT unconditionally.
REQ-017 ST_WAIT SHALL hold TX_DATA_O stable and return to ST_IDLE on the edge after TX_DONE_I=1.
REQ-018 TX_DONE_I SHALL be ignored in ST_IDLE and ST_START.
REQ-019 Latency: a byte pushed at edge N into an empty queue in ST_IDLE SHALL produce TX_START_O=1 during the cycle after edge N+1.
REQ-020 Back-to-back: with the queue non-empty, the next TX_START_O SHALL occur 2 cycles after the TX_DONE_I cycle.
REQ-021 A push and a pop in the same cycle SHALL leave COUNT_O unchanged and preserve byte order.
REQ-022 A push while FULL_O=1 SHALL be refused; storage and COUNT_O are unchanged.
REQ-023 A push into an empty queue SHALL NOT bypass into the same-cycle pop; the pop sees the byte one cycle later.
REQ-024 Bytes SHALL be transmitted strictly in push order across pointer wrap-around.
REQ-025 FULL_O, EMPTY_O, READY_O, and COUNT_O SHALL be registered-state-derived, with no combinational path from VALID_I.

Reset
REQ-026 Asserting RST_NI=0 SHALL asynchronously set the FSM to ST_IDLE, clear both pointers and COUNT_O, and force TX_START_O=0 and TX_DATA_O=0.
REQ-027 After reset, outputs SHALL be EMPTY_O=1, FULL_O=0, and READY_O=1.
REQ-028 Reset mid-transmission SHALL discard queued bytes and the in-flight byte, with no TX_START_O until a new push.
REQ-029 FIFO storage contents SHALL NOT require reset.

Structure
REQ-030 The state enum (uart_tx_queue_state_t) SHALL reside in the shared package uart_pkg.
REQ-031 The byte width constant UART_DATA_W=8 SHALL reside in the shared package uart_pkg.
REQ-032 Storage and pointers SHALL be one sub-module, uart_fifo, parameterised by DEPTH and width.
REQ-033 The FSM and holding register SHALL be in uart_tx_queue.
REQ-034 TX_START_O, TX_DATA_O, and TX_DONE_I SHALL connect directly to the transmitter's start, data, and done ports.

Verification
REQ-035 Reset, then push 0xA5 -> TX_START_O pulses one cycle with TX_DATA_O=0xA5, EMPTY_O=1, and no further start until TX_DONE_I.
REQ-036 Push 0x01..0x08 at DEPTH=8 while transmitter busy -> after the first pop, COUNT_O reaches 7, then FULL_O=1 after the ninth push, and a tenth push with 0xFF is refused.
REQ-037 Pulse TX_DONE_I repeatedly -> the order out is 0x01..0x09, each start exactly 2 cycles after its TX_DONE_I, and the 0xFF push that was refused never appears.
REQ-038 Simultaneous push 0x55 and pop at COUNT_O=3 -> COUNT_O stays 3 and 0x55 is transmitted after the three earlier bytes.
REQ-039 Twenty bytes streamed through with pointer wrap -> all twenty bytes are transmitted in order with no loss.
REQ-040 Assert RST_NI=0 in ST_WAIT with COUNT_O=4 -> the block immediately shows EMPTY_O=1 and TX_START_O=0, and no start occurs after release without a push.
